psum_wb_stream: RTL and testbench
=================================

PSUM_WB_STREAM -- requirements
Module: psum_wb_stream

Interface
REQ-001 Parameter NUM_BANK, default 32: number of psum banks captured per writeback; legal range 2..64.
REQ-002 Parameter BIT_PSUM, default 24: width of one psum word.
REQ-003 Parameter BIT_BANK_ID, default 5: bank index width; SHALL equal ceil(log2(NUM_BANK)).
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RSTb  input  1  reset; synchronous and active-low.
REQ-006 i_Cap_Valid  input  1  capture request.
REQ-007 o_Cap_Ready  output  1  block can accept a capture.
REQ-008 i_Cap_Mask  input  NUM_BANK  bank enables for the capture; bit k selects bank k.
REQ-009 i_Cap_Data  input  NUM_BANK*BIT_PSUM  bank k occupies bits [k*BIT_PSUM +: BIT_PSUM].
REQ-010 i_Cap_Desc  input  1  drain order for the capture: 0 = ascending bank index, 1 = descending.
REQ-011 o_Valid  output  1  output beat valid.
REQ-012 i_Ready  input  1  downstream accepts the beat.
REQ-013 o_Data  output  BIT_PSUM  psum word of the current beat.
REQ-014 o_Bank  output  BIT_BANK_ID  bank index of the current beat.
REQ-015 o_Last  output  1  current beat is the final beat of the capture.
REQ-016 o_Beat_Cnt  output  16  total beats transferred since reset; wraps 0xFFFF -> 0.

Function
REQ-017 Two states SHALL exist, IDLE and SEND; o_Cap_Ready SHALL be 1 exactly in IDLE.
REQ-018 A capture SHALL be accepted on a rising edge where i_Cap_Valid=1 and o_Cap_Ready=1; the block SHALL register data, mask and order on that edge.
REQ-019 If the accepted mask is nonzero, the block SHALL enter SEND, and o_Valid SHALL assert in the first cycle after acceptance (latency 1).
REQ-020 If the accepted mask is zero, the block SHALL remain in IDLE, SHALL emit no beat, and o_Cap_Ready SHALL stay 1.
REQ-021 In SEND, the beat SHALL present the lowest remaining set bank (ascending order) or the highest remaining set bank (descending order), together with its data and index.
REQ-022 A beat SHALL transfer on an edge where o_Valid=1 and i_Ready=1; that bank's remaining-mask bit SHALL clear and o_Beat_Cnt SHALL increment on that edge.
REQ-023 While o_Valid=1 and i_Ready=0, o_Data, o_Bank and o_Last SHALL hold stable.
REQ-024 Beats SHALL be back-to-back (one beat per cycle) while i_Ready=1.
REQ-025 o_Last SHALL be 1 only when exactly one remaining bit is set.
REQ-026 On transfer of the o_Last beat, the block SHALL return to IDLE, with o_Valid=0 and o_Cap_Ready=1 in the next cycle.
REQ-027 i_Cap_Valid, i_Cap_Mask, i_Cap_Data and i_Cap_Desc SHALL be ignored while in SEND; no capture is queued.
REQ-028 When o_Valid=0, o_Data, o_Bank and o_Last SHALL be 0.

Reset
REQ-029 When RSTb=0 at a rising edge, the block SHALL enter IDLE, clear the remaining mask, the data buffer and o_Beat_Cnt, and abort any capture in progress; after that edge o_Valid=0, o_Last=0, o_Data=0, o_Bank=0, o_Cap_Ready=1 and o_Beat_Cnt=0.
REQ-030 Reset SHALL take priority over capture and beat transfer on the same edge.

Configuration
REQ-031 With macro PSUM_WB_RELU_EN defined, o_Data SHALL be 0 whenever the buffered word is negative (two's complement, MSB=1) and SHALL otherwise pass unchanged; the clamp is applied to the output only, and the buffer is not modified.
REQ-032 Without PSUM_WB_RELU_EN, o_Data SHALL be the buffered word unchanged.

Verification
REQ-033 Ascending drain: mask 0x00000005, desc=0, bank0=0x000010, bank2=0x000020, i_Ready=1 -> beats (bank 0, 0x000010, last=0) then (bank 2, 0x000020, last=1); o_Cap_Ready=1 one cycle after the second beat; o_Beat_Cnt=2.
REQ-034 Descending drain with backpressure: mask 0x80000001, desc=1, i_Ready held 0 for 3 cycles -> bank 31 held stable for 4 cycles, then bank 0 with last=1.
REQ-035 Zero mask: capture with mask 0 -> no o_Valid pulse; o_Cap_Ready stays 1; o_Beat_Cnt unchanged.
REQ-036 Reset mid-drain: mask 0xFFFFFFFF, RSTb=0 after 5 beats -> next cycle o_Valid=0, o_Cap_Ready=1, o_Beat_Cnt=0.
REQ-037 RELU: bank 3=0xFFFFF0, mask 0x8 -> o_Data=0 with PSUM_WB_RELU_EN defined, and 0xFFFFF0 without it.
REQ-038 Capture during SEND: i_Cap_Valid pulsed mid-drain -> pulse ignored and the original sequence completes unchanged.

Source files
------------

// File: rtl/psum_wb_stream.sv
// psum_wb_stream: captures a masked set of psum banks in one cycle and
// streams the selected banks out one beat at a time, in ascending or
// descending bank order, under valid/ready handshaking.
//
// Optional feature: define PSUM_WB_RELU_EN to clamp negative output words
// to zero. The clamp acts on o_Data only; the capture buffer keeps the raw
// value.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a capture; o_Cap_Ready=1, no beat presented
// SEND  | draining the remaining mask, one bank per accepted beat
module psum_wb_stream #(
  parameter int NUM_BANK    = 32,
  parameter int BIT_PSUM    = 24,
  parameter int BIT_BANK_ID = 5
) (
  input  logic                         CLK,
  input  logic                         RSTb,
  input  logic                         i_Cap_Valid,
  output logic                         o_Cap_Ready,
  input  logic [NUM_BANK-1:0]          i_Cap_Mask,
  input  logic [NUM_BANK*BIT_PSUM-1:0] i_Cap_Data,
  input  logic                         i_Cap_Desc,
  output logic                         o_Valid,
  input  logic                         i_Ready,
  output logic [BIT_PSUM-1:0]          o_Data,
  output logic [BIT_BANK_ID-1:0]       o_Bank,
  output logic                         o_Last,
  output logic [15:0]                  o_Beat_Cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_BANK-1:0]   rem_q;
  logic [NUM_BANK-1:0]   rem_d;
  logic [BIT_PSUM-1:0]   buf_q [NUM_BANK];
  logic                  desc_q;
  logic [15:0]           beat_cnt_q;
  logic [BIT_BANK_ID-1:0] sel;
  logic                  one_left;
  logic                  cap_take;
  logic                  beat_take;
  logic [BIT_PSUM-1:0]   word;
  logic [BIT_PSUM-1:0]   word_out;

  assign cap_take  = (state_q == IDLE) && i_Cap_Valid;
  assign beat_take = (state_q == SEND) && i_Ready;

  // Pick the next bank: the loop direction makes the last set bit visited
  // win, so visiting high-to-low yields the lowest set bank and vice versa.
  always_comb begin
    sel = '0;
    if (desc_q) begin
      for (int k = 0; k < NUM_BANK; k++)
        if (rem_q[k]) sel = BIT_BANK_ID'(k);
    end else begin
      for (int k = NUM_BANK - 1; k >= 0; k--)
        if (rem_q[k]) sel = BIT_BANK_ID'(k);
    end
  end

  // Exactly one bit remaining: nonzero and clearing the lowest bit leaves zero.
  assign one_left = (rem_q != '0) &&
                    ((rem_q & (rem_q - NUM_BANK'(1))) == '0);

  // Remaining mask after the current bank is sent.
  always_comb begin
    rem_d      = rem_q;
    rem_d[sel] = 1'b0;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a zero-mask capture is accepted but leaves us in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_Cap_Valid && (i_Cap_Mask != '0)) state_d = SEND;
      SEND: if (i_Ready && one_left)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture buffer, remaining mask, drain order and beat counter.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      rem_q      <= '0;
      desc_q     <= 1'b0;
      beat_cnt_q <= '0;
      for (int k = 0; k < NUM_BANK; k++) buf_q[k] <= '0;
    end else if (cap_take) begin
      rem_q  <= i_Cap_Mask;
      desc_q <= i_Cap_Desc;
      for (int k = 0; k < NUM_BANK; k++)
        buf_q[k] <= i_Cap_Data[k*BIT_PSUM +: BIT_PSUM];
    end else if (beat_take) begin
      rem_q      <= rem_d;
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign word = buf_q[sel];

  // Output word, optionally clamped at zero for negative values.
  always_comb begin
`ifdef PSUM_WB_RELU_EN
    word_out = word[BIT_PSUM-1] ? '0 : word;
`else
    word_out = word;
`endif
  end

  assign o_Cap_Ready = (state_q == IDLE);
  assign o_Valid     = (state_q == SEND);
  assign o_Data      = o_Valid ? word_out : '0;
  assign o_Bank      = o_Valid ? sel : '0;
  assign o_Last      = o_Valid & one_left;
  assign o_Beat_Cnt  = beat_cnt_q;

endmodule

// File: tb/tb_psum_wb_stream.sv
// Directed bench for psum_wb_stream with the default 32 x 24-bit geometry.
module tb_psum_wb_stream;

  localparam int NB = 32;
  localparam int BP = 24;
  localparam int BI = 5;

  logic              CLK;
  logic              RSTb;
  logic              i_Cap_Valid;
  logic              o_Cap_Ready;
  logic [NB-1:0]     i_Cap_Mask;
  logic [NB*BP-1:0]  i_Cap_Data;
  logic              i_Cap_Desc;
  logic              o_Valid;
  logic              i_Ready;
  logic [BP-1:0]     o_Data;
  logic [BI-1:0]     o_Bank;
  logic              o_Last;
  logic [15:0]       o_Beat_Cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  psum_wb_stream #(.NUM_BANK(NB), .BIT_PSUM(BP), .BIT_BANK_ID(BI)) dut (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .i_Cap_Valid(i_Cap_Valid),
    .o_Cap_Ready(o_Cap_Ready),
    .i_Cap_Mask (i_Cap_Mask),
    .i_Cap_Data (i_Cap_Data),
    .i_Cap_Desc (i_Cap_Desc),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Data     (o_Data),
    .o_Bank     (o_Bank),
    .o_Last     (o_Last),
    .o_Beat_Cnt (o_Beat_Cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTb = 1'b0;
    tick();
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_Cap_Ready !== 1'b1) $display("FAIL rst_ready got %0h exp 1", o_Cap_Ready); else pass_cnt++;
    total_cnt++; if (o_Beat_Cnt !== 16'd0) $display("FAIL rst_cnt got %0h exp 0", o_Beat_Cnt); else pass_cnt++;
    total_cnt++; if ({o_Data, o_Bank, o_Last} !== '0) $display("FAIL rst_outs got %0h/%0h/%0h exp 0", o_Data, o_Bank, o_Last); else pass_cnt++;
    RSTb = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    i_Cap_Data = '0;
    i_Cap_Data[0*BP +: BP] = 24'h000010;
    i_Cap_Data[2*BP +: BP] = 24'h000020;
    i_Cap_Mask  = 32'h0000_0005;
    i_Cap_Desc  = 1'b0;
    i_Cap_Valid = 1'b1;
    i_Ready     = 1'b1;
    tick();
    i_Cap_Valid = 1'b0;
    total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd0, 24'h000010, 1'b0})
      $display("FAIL asc_beat0 got v%0h b%0d d%0h l%0h exp v1 b0 d10 l0", o_Valid, o_Bank, o_Data, o_Last); else pass_cnt++;
    total_cnt++; if (o_Cap_Ready !== 1'b0) $display("FAIL asc_busy got %0h exp 0", o_Cap_Ready); else pass_cnt++;
    tick();
    total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd2, 24'h000020, 1'b1})
      $display("FAIL asc_beat1 got v%0h b%0d d%0h l%0h exp v1 b2 d20 l1", o_Valid, o_Bank, o_Data, o_Last); else pass_cnt++;
    tick();
    total_cnt++; if ({o_Valid, o_Cap_Ready} !== 2'b01) $display("FAIL asc_done got v%0h r%0h exp v0 r1", o_Valid, o_Cap_Ready); else pass_cnt++;
    total_cnt++; if (o_Beat_Cnt !== 16'd2) $display("FAIL asc_cnt got %0d exp 2", o_Beat_Cnt); else pass_cnt++;
    total_cnt++; if ({o_Data, o_Bank, o_Last} !== '0) $display("FAIL asc_idle_outs got %0h/%0h/%0h exp 0", o_Data, o_Bank, o_Last); else pass_cnt++;
  endtask

  task automatic test_desc_backpressure();
    i_Cap_Data = '0;
    i_Cap_Data[31*BP +: BP] = 24'hABCDEF;
    i_Cap_Data[0*BP +: BP]  = 24'h123456;
    i_Cap_Mask  = 32'h8000_0001;
    i_Cap_Desc  = 1'b1;
    i_Cap_Valid = 1'b1;
    i_Ready     = 1'b0;
    tick();
    i_Cap_Valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd31, 24'hABCDEF, 1'b0})
        $display("FAIL desc_hold%0d got v%0h b%0d d%0h l%0h exp v1 b31 dabcdef l0", c, o_Valid, o_Bank, o_Data, o_Last); else pass_cnt++;
      i_Ready = (c == 3);
      tick();
    end
    total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd0, 24'h123456, 1'b1})
      $display("FAIL desc_last got v%0h b%0d d%0h l%0h exp v1 b0 d123456 l1", o_Valid, o_Bank, o_Data, o_Last); else pass_cnt++;
    tick();
    total_cnt++; if ({o_Valid, o_Cap_Ready} !== 2'b01) $display("FAIL desc_done got v%0h r%0h exp v0 r1", o_Valid, o_Cap_Ready); else pass_cnt++;
    total_cnt++; if (o_Beat_Cnt !== 16'd4) $display("FAIL desc_cnt got %0d exp 4", o_Beat_Cnt); else pass_cnt++;
  endtask

  task automatic test_zero_mask();
    i_Cap_Data  = '1;
    i_Cap_Mask  = '0;
    i_Cap_Desc  = 1'b0;
    i_Cap_Valid = 1'b1;
    i_Ready     = 1'b1;
    tick();
    i_Cap_Valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++; if ({o_Valid, o_Cap_Ready} !== 2'b01) $display("FAIL zero_idle%0d got v%0h r%0h exp v0 r1", c, o_Valid, o_Cap_Ready); else pass_cnt++;
      tick();
    end
    total_cnt++; if (o_Beat_Cnt !== 16'd4) $display("FAIL zero_cnt got %0d exp 4", o_Beat_Cnt); else pass_cnt++;
  endtask

  task automatic test_capture_during_send();
    i_Cap_Data = '0;
    i_Cap_Data[1*BP +: BP] = 24'h000111;
    i_Cap_Data[2*BP +: BP] = 24'h000222;
    i_Cap_Data[4*BP +: BP] = 24'h000444;
    i_Cap_Mask  = 32'h0000_0016;
    i_Cap_Desc  = 1'b0;
    i_Cap_Valid = 1'b1;
    i_Ready     = 1'b1;
    tick();
    total_cnt++; if ({o_Valid, o_Bank, o_Data} !== {1'b1, 5'd1, 24'h000111})
      $display("FAIL busy_beat0 got v%0h b%0d d%0h exp v1 b1 d111", o_Valid, o_Bank, o_Data); else pass_cnt++;
    i_Cap_Data = '1;
    i_Cap_Mask = 32'h0000_0001;
    i_Cap_Desc = 1'b1;
    tick();
    i_Cap_Valid = 1'b0;
    total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd2, 24'h000222, 1'b0})
      $display("FAIL busy_beat1 got v%0h b%0d d%0h l%0h exp v1 b2 d222 l0", o_Valid, o_Bank, o_Data, o_Last); else pass_cnt++;
    tick();
    total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd4, 24'h000444, 1'b1})
      $display("FAIL busy_beat2 got v%0h b%0d d%0h l%0h exp v1 b4 d444 l1", o_Valid, o_Bank, o_Data, o_Last); else pass_cnt++;
    tick();
    total_cnt++; if ({o_Valid, o_Cap_Ready} !== 2'b01) $display("FAIL busy_done got v%0h r%0h exp v0 r1", o_Valid, o_Cap_Ready); else pass_cnt++;
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL busy_no_queue got %0h exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_Beat_Cnt !== 16'd7) $display("FAIL busy_cnt got %0d exp 7", o_Beat_Cnt); else pass_cnt++;
  endtask

  task automatic test_relu();
    logic [BP-1:0] exp_data;
`ifdef PSUM_WB_RELU_EN
    exp_data = 24'h000000;
`else
    exp_data = 24'hFFFFF0;
`endif
    i_Cap_Data = '0;
    i_Cap_Data[3*BP +: BP] = 24'hFFFFF0;
    i_Cap_Mask  = 32'h0000_0008;
    i_Cap_Desc  = 1'b0;
    i_Cap_Valid = 1'b1;
    i_Ready     = 1'b1;
    tick();
    i_Cap_Valid = 1'b0;
    total_cnt++; if ({o_Valid, o_Bank, o_Data, o_Last} !== {1'b1, 5'd3, exp_data, 1'b1})
      $display("FAIL relu_beat got v%0h b%0d d%0h l%0h exp v1 b3 d%0h l1", o_Valid, o_Bank, o_Data, o_Last, exp_data); else pass_cnt++;
    tick();
    total_cnt++; if (o_Beat_Cnt !== 16'd8) $display("FAIL relu_cnt got %0d exp 8", o_Beat_Cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    i_Cap_Data = '0;
    for (int k = 0; k < NB; k++) i_Cap_Data[k*BP +: BP] = BP'(k + 1);
    i_Cap_Mask  = '1;
    i_Cap_Desc  = 1'b0;
    i_Cap_Valid = 1'b1;
    i_Ready     = 1'b1;
    tick();
    i_Cap_Valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total_cnt++; if ({o_Valid, o_Bank, o_Data} !== {1'b1, BI'(k), BP'(k + 1)})
        $display("FAIL full_beat%0d got v%0h b%0d d%0h exp v1 b%0d d%0h", k, o_Valid, o_Bank, o_Data, k, k + 1); else pass_cnt++;
      tick();
    end
    total_cnt++; if (o_Beat_Cnt !== 16'd13) $display("FAIL full_cnt got %0d exp 13", o_Beat_Cnt); else pass_cnt++;
    RSTb = 1'b0;
    tick();
    total_cnt++; if ({o_Valid, o_Cap_Ready, o_Last} !== 3'b010) $display("FAIL mid_rst got v%0h r%0h l%0h exp v0 r1 l0", o_Valid, o_Cap_Ready, o_Last); else pass_cnt++;
    total_cnt++; if (o_Beat_Cnt !== 16'd0) $display("FAIL mid_rst_cnt got %0d exp 0", o_Beat_Cnt); else pass_cnt++;
    RSTb = 1'b1;
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL post_rst_valid got %0h exp 0", o_Valid); else pass_cnt++;
  endtask

  initial begin
    RSTb        = 1'b0;
    i_Cap_Valid = 1'b0;
    i_Cap_Mask  = '0;
    i_Cap_Data  = '0;
    i_Cap_Desc  = 1'b0;
    i_Ready     = 1'b0;
    test_reset();
    test_ascending();
    test_desc_backpressure();
    test_zero_mask();
    test_capture_during_send();
    test_relu();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
